// File: rtl/bus_arb_pkg.sv
// Shared types for the I/D bus arbiter: FSM states, master identities
// and the tag bit that marks a write transaction.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    typedef enum logic {
        M_I,
        M_D
    } master_e;

    localparam int unsigned DEF_BUS_TAG_WIDTH = 13;
    localparam int unsigned WRITE_TAG_BIT     = DEF_BUS_TAG_WIDTH - 1;

    function automatic logic [1:0] master_onehot(input master_e m);
        return (m == M_D) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory bus between the I-cache
// and D-cache; the bus is held for a whole read or write transaction.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned RESP_BEATS     = 8,
    parameter int unsigned WR_BEATS       = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      i_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
    input  logic                      i_respack,

    input  logic                      d_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
    input  logic                      d_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,

    output logic [1:0]                grant,
    output logic                      stray_resp
);

    localparam int unsigned WR_BIT = BUS_TAG_WIDTH - 1;

    state_e     r_state, w_state_nx;
    logic [1:0] r_grant, w_grant_nx;
    master_e    r_last,  w_last_nx;
    logic [3:0] r_cnt,   w_cnt_nx;
    master_e    w_win;

    logic                      w_sel_d;
    logic                      w_in_req;
    logic                      w_in_resp;
    logic                      w_sel_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] w_sel_req;
    logic [BUS_TAG_WIDTH-1:0]  w_sel_reqtag;
    logic                      w_sel_respack;
    logic                      w_req_acc;
    logic                      w_resp_acc;

    assign w_sel_d       = r_grant[1];
    assign w_in_req      = (r_state == REQ);
    assign w_in_resp     = (r_state == RESP);
    assign w_sel_reqcyc  = w_sel_d ? d_reqcyc  : i_reqcyc;
    assign w_sel_req     = w_sel_d ? d_req     : i_req;
    assign w_sel_reqtag  = w_sel_d ? d_reqtag  : i_reqtag;
    assign w_sel_respack = w_sel_d ? d_respack : i_respack;

    assign w_req_acc  = bus_reqcyc & bus_reqack;
    assign w_resp_acc = bus_respcyc & bus_respack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= M_I;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        w_win      = M_I;
        case (r_state)
            IDLE: begin
                if (i_reqcyc || d_reqcyc) begin
                    // On a tie the master that did not own the previous grant wins.
                    if (i_reqcyc && d_reqcyc)
                        w_win = (r_last == M_I) ? M_D : M_I;
                    else
                        w_win = d_reqcyc ? M_D : M_I;
                    w_grant_nx = master_onehot(w_win);
                    w_last_nx  = w_win;
                    w_cnt_nx   = '0;
                    w_state_nx = REQ;
                end
            end
            REQ: begin
                if (w_req_acc) begin
                    if (r_cnt == '0 && !w_sel_reqtag[WR_BIT]) begin
                        w_state_nx = RESP;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == 4'(WR_BEATS)) begin
                        w_state_nx = IDLE;
                        w_grant_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
            end
            RESP: begin
                if (w_resp_acc) begin
                    if (r_cnt == 4'(RESP_BEATS - 1)) begin
                        w_state_nx = IDLE;
                        w_grant_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign bus_reqcyc  = w_in_req & w_sel_reqcyc;
    assign bus_req     = w_in_req ? w_sel_req    : '0;
    assign bus_reqtag  = w_in_req ? w_sel_reqtag : '0;
    assign bus_respack = w_in_resp & w_sel_respack;

    assign i_reqack  = w_in_req  & r_grant[0] & bus_reqack;
    assign d_reqack  = w_in_req  & r_grant[1] & bus_reqack;
    assign i_respcyc = w_in_resp & r_grant[0] & bus_respcyc;
    assign d_respcyc = w_in_resp & r_grant[1] & bus_respcyc;

    assign i_resp    = bus_resp;
    assign d_resp    = bus_resp;
    assign i_resptag = bus_resptag;
    assign d_resptag = bus_resptag;

    // Gated by reset so the pulse also drops while reset is held low.
    assign stray_resp = reset & bus_respcyc & ~w_in_resp;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter against a transaction-level
// model that counts remaining beats per owner.
module tb_bus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int RB = 8;
    localparam int WB = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_reqcyc, d_reqcyc;
    logic [DW-1:0] i_req, d_req;
    logic [TW-1:0] i_reqtag, d_reqtag;
    logic          i_reqack, d_reqack;
    logic          i_respcyc, d_respcyc;
    logic [DW-1:0] i_resp, d_resp;
    logic [TW-1:0] i_resptag, d_resptag;
    logic          i_respack, d_respack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;
    logic [1:0]    grant;
    logic          stray_resp;

    always #5 clk = ~clk;

    bus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .RESP_BEATS     (RB),
        .WR_BEATS       (WB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_reqcyc    (i_reqcyc),
        .i_req       (i_req),
        .i_reqtag    (i_reqtag),
        .i_reqack    (i_reqack),
        .i_respcyc   (i_respcyc),
        .i_resp      (i_resp),
        .i_resptag   (i_resptag),
        .i_respack   (i_respack),
        .d_reqcyc    (d_reqcyc),
        .d_req       (d_req),
        .d_reqtag    (d_reqtag),
        .d_reqack    (d_reqack),
        .d_respcyc   (d_respcyc),
        .d_resp      (d_resp),
        .d_resptag   (d_resptag),
        .d_respack   (d_respack),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .grant       (grant),
        .stray_resp  (stray_resp)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: owner 0 = nobody, 1 = I-side, 2 = D-side.
    int owner;
    int req_done;
    int resp_done;
    bit in_resp;
    int last_owner;
    int n_grants;
    int n_alt_checked;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner      = 0;
        req_done   = 0;
        resp_done  = 0;
        in_resp    = 0;
        last_owner = 1;
    endtask

    task automatic check_outputs();
        bit          mreq, mresp, s_reqcyc, s_respack;
        logic [63:0] s_req;
        logic [12:0] s_tag;
        mreq      = (owner != 0) && !in_resp;
        mresp     = (owner != 0) && in_resp;
        s_reqcyc  = (owner == 2) ? d_reqcyc  : i_reqcyc;
        s_req     = (owner == 2) ? d_req     : i_req;
        s_tag     = (owner == 2) ? d_reqtag  : i_reqtag;
        s_respack = (owner == 2) ? d_respack : i_respack;
        check("grant",      64'(grant), (owner == 1) ? 64'd1 : (owner == 2) ? 64'd2 : 64'd0);
        check("bus_reqcyc", 64'(bus_reqcyc), 64'(mreq && s_reqcyc));
        check("bus_req",    bus_req, mreq ? s_req : 64'd0);
        check("bus_reqtag", 64'(bus_reqtag), mreq ? 64'(s_tag) : 64'd0);
        check("i_reqack",   64'(i_reqack), 64'(mreq && owner == 1 && bus_reqack));
        check("d_reqack",   64'(d_reqack), 64'(mreq && owner == 2 && bus_reqack));
        check("i_respcyc",  64'(i_respcyc), 64'(mresp && owner == 1 && bus_respcyc));
        check("d_respcyc",  64'(d_respcyc), 64'(mresp && owner == 2 && bus_respcyc));
        check("bus_respack",64'(bus_respack), 64'(mresp && s_respack));
        check("stray_resp", 64'(stray_resp), 64'(bus_respcyc && !mresp));
        check("i_resp",     i_resp, bus_resp);
        check("d_resptag",  64'(d_resptag), 64'(bus_resptag));
    endtask

    task automatic model_step();
        bit          s_reqcyc, s_respack;
        logic [12:0] s_tag;
        s_reqcyc  = (owner == 2) ? d_reqcyc  : i_reqcyc;
        s_respack = (owner == 2) ? d_respack : i_respack;
        s_tag     = (owner == 2) ? d_reqtag  : i_reqtag;
        if (owner == 0) begin
            if (i_reqcyc || d_reqcyc) begin
                if (i_reqcyc && d_reqcyc) owner = (last_owner == 1) ? 2 : 1;
                else                      owner = d_reqcyc ? 2 : 1;
                last_owner = owner;
                req_done   = 0;
                resp_done  = 0;
                in_resp    = 0;
                n_grants++;
            end
        end else if (!in_resp) begin
            if (s_reqcyc && bus_reqack) begin
                req_done++;
                if (req_done == 1 && !s_tag[12]) in_resp = 1;
                else if (req_done == 1 + WB)     owner = 0;
            end
        end else begin
            if (bus_respcyc && s_respack) begin
                resp_done++;
                if (resp_done == RB) owner = 0;
            end
        end
    endtask

    task automatic drive_rand();
        i_reqcyc    = ($urandom % 4) != 0;
        d_reqcyc    = ($urandom % 4) != 0;
        i_req       = {$urandom, $urandom};
        d_req       = {$urandom, $urandom};
        i_reqtag    = TW'($urandom);
        d_reqtag    = TW'($urandom);
        i_respack   = ($urandom % 4) != 0;
        d_respack   = ($urandom % 4) != 0;
        bus_reqack  = ($urandom % 3) != 0;
        bus_respcyc = ($urandom % 2) != 0;
        bus_resp    = {$urandom, $urandom};
        bus_resptag = TW'($urandom);
    endtask

    initial begin
        reset       = 1'b0;
        i_reqcyc    = 1'b0; d_reqcyc  = 1'b0;
        i_req       = '0;   d_req     = '0;
        i_reqtag    = '0;   d_reqtag  = '0;
        i_respack   = 1'b0; d_respack = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = '0;
        bus_resptag = '0;
        n_grants    = 0;
        n_alt_checked = 0;
        model_reset();

        #12;
        check("rst_grant",   64'(grant), 64'd0);
        check("rst_reqcyc",  64'(bus_reqcyc), 64'd0);
        check("rst_respack", 64'(bus_respack), 64'd0);
        check("rst_stray",   64'(stray_resp), 64'd0);
        check("rst_irespcyc",64'(i_respcyc), 64'd0);

        @(posedge clk); #1;
        reset = 1'b1;
        bus_respcyc = 1'b0;

        // Tie straight out of reset: D-side must win first.
        i_reqcyc = 1'b1; d_reqcyc = 1'b1;
        #4;
        check_outputs();
        model_step();
        @(posedge clk); #1;
        check("first_tie", 64'(grant), 64'd2);

        for (int cyc = 0; cyc < 6000; cyc++) begin
            drive_rand();
            #4;
            check_outputs();
            if (owner != 0 && ($urandom % 400) == 0) begin
                #1 reset = 1'b0;
                #1;
                check("async_grant",   64'(grant), 64'd0);
                check("async_reqcyc",  64'(bus_reqcyc), 64'd0);
                check("async_respack", 64'(bus_respack), 64'd0);
                check("async_acks",    64'({i_reqack, d_reqack, i_respcyc, d_respcyc}), 64'd0);
                check("async_stray",   64'(stray_resp), 64'd0);
                model_reset();
                @(posedge clk); #1;
                reset = 1'b1;
            end else begin
                model_step();
                @(posedge clk); #1;
            end
        end

        check("grants_seen", 64'(n_grants > 50), 64'd1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single memory bus port between the instruction-fetch cache (I-side) and the data cache (D-side). It sits between both caches and the top-level bus pins. It grants the bus for one whole transaction at a time: a read request beat plus its response burst, or a write address beat plus its data beats. Requests, tags, acks and response beats are steered between the granted master and the bus, and round-robin fairness is applied when both masters request together.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, request/response beat width
- BUS_TAG_WIDTH, 13, tag width; tag MSB set = write, clear = read
- RESP_BEATS, 8, response beats per read (one 512-bit line)
- WR_BEATS, 8, data beats following a write address beat

Ports (clock and reset first; prefix `m` = `i` or `d`, one copy per master):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- m_reqcyc  in  1  master request valid
- m_req  in  BUS_DATA_WIDTH  master request beat
- m_reqtag  in  BUS_TAG_WIDTH  master request tag
- m_reqack  out  1  request beat accepted by bus
- m_respcyc  out  1  response beat valid for this master
- m_resp  out  BUS_DATA_WIDTH  response beat (same value to both masters)
- m_resptag  out  BUS_TAG_WIDTH  response tag (same value to both masters)
- m_respack  in  1  master accepts response beat
- bus_reqcyc  out  1  request valid to bus
- bus_req  out  BUS_DATA_WIDTH
- bus_reqtag  out  BUS_TAG_WIDTH
- bus_reqack  in  1
- bus_respcyc  in  1
- bus_resp  in  BUS_DATA_WIDTH
- bus_resptag  in  BUS_TAG_WIDTH
- bus_respack  out  1
- grant  out  2  one-hot owner: bit0 = I-side, bit1 = D-side, 00 = idle
- stray_resp  out  1  one-cycle pulse: bus_respcyc arrived with no read outstanding

## Operation
- States: IDLE, REQ, RESP.
- IDLE:
  - Any m_reqcyc high → register the winner into grant and go to REQ.
  - Both requesting → the master not granted last wins. After reset, D-side wins.
- REQ:
  - bus_reqcyc/bus_req/bus_reqtag = granted master's signals. m_reqack = bus_reqack, granted master only.
  - A beat is accepted on any cycle with bus_reqcyc & bus_reqack.
  - Read (tag MSB 0) → after 1 accepted beat, go to RESP.
  - Write → after 1 + WR_BEATS accepted beats, go to IDLE and clear grant.
- RESP:
  - Granted master's m_respcyc = bus_respcyc. bus_respack = granted master's m_respack.
  - A beat is accepted on bus_respcyc & bus_respack.
  - After RESP_BEATS accepted beats, go to IDLE and clear grant.
- Beat counter is 4 bits and cleared on every grant. The count compares against the parameter and never wraps inside a transaction.
- The non-granted master sees m_reqack = 0 and m_respcyc = 0 at all times.
- Masters hold m_reqcyc until their first m_reqack. A grant is never revoked mid-transaction, even if m_reqcyc drops.
- Response in IDLE or REQ: bus_respack stays 0 and stray_resp pulses for every such cycle.
- Tag width rule: only bit BUS_TAG_WIDTH-1 is decoded; the tag passes through unmodified.

## Timing
- Reset values: grant = 00; bus_reqcyc, bus_respack, all m_reqack, all m_respcyc, stray_resp = 0; state IDLE; last-grant = I-side (so D-side wins first tie).
- Arbitration latency: m_reqcyc seen in IDLE → grant and bus_reqcyc asserted the next cycle.
- Steering paths in REQ/RESP are combinational, with zero added latency.
- Back-to-back: a master requesting in the cycle grant clears is arbitrated from IDLE the following cycle. Minimum one idle cycle between transactions.
- Reset asserted mid-transaction: all outputs drop asynchronously and the beat count is lost. Masters must restart their transactions.

## Structure
- Package bus_arb_pkg holds:
  - state enum {IDLE, REQ, RESP}
  - master enum {M_I, M_D}
  - constant WRITE_TAG_BIT = BUS_TAG_WIDTH-1
- Flat module; arbitration is a 2-input round-robin, so no sub-module.

## Test plan
- I-side read alone: i_reqcyc with tag 0x0000 → grant = 01 next cycle; one reqack, then 8 response beats delivered only on i_respcyc; grant = 00 after the 8th ack.
- D-side write: d tag 0x1000 → 9 accepted request beats, no response phase; grant = 00 after the 9th bus_reqack.
- Simultaneous requests from reset → D granted first, then I. Repeat both requesting → grants alternate D, I, D, I.
- Response stalls: bus_respcyc high with i_respack low for 3 cycles → beat count unchanged; completion after exactly 8 acked beats.
- Stray response: bus_respcyc while IDLE → stray_resp = 1 that cycle, bus_respack = 0, no m_respcyc.
- Reset low during beat 4 of a read → all outputs 0 immediately. After release, a new I read completes normally with 8 beats.
